change_dispenser: RTL and testbench

Change-dispensing controller for the vending machine. After a purchase or cancel, the control unit hands it an amount owed. It then sequences the coin-ejector mechanism with a greedy 50/20/10-sen algorithm, tracks the coins held in each tube, and reports completion, shortfall or jam back to the control unit. It sits between the control unit / change register and the physical coin ejector, and is the only block that drives the ejector.

---
 rtl/change_dispenser.sv | 170 +++++++++++++++++
 tb/tb_change_dispenser.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// change_dispenser : greedy 50/20/10-sen change dispenser with tube inventory
// Revision: 1.0
// ============================================================================
module change_dispenser #(
    parameter int AW      = 8,
    parameter int TIMEOUT = 200
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] amount,
    input  logic          refill,
    input  logic [1:0]    refill_sel,
    input  logic [AW-1:0] refill_qty,
    input  logic          jam_clr,
    input  logic          eject_ack,
    output logic [2:0]    eject_req,
    output logic          busy,
    output logic          done,
    output logic          short,
    output logic          jam,
    output logic [AW-1:0] remain,
    output logic [AW-1:0] cnt10,
    output logic [AW-1:0] cnt20,
    output logic [AW-1:0] cnt50
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PICK    = 3'd1,
        S_EJECT   = 3'd2,
        S_RELEASE = 3'd3,
        S_DONE    = 3'd4,
        S_JAM     = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] remain_q, remain_d;
    logic [AW-1:0] cnt10_q, cnt10_d, cnt20_q, cnt20_d, cnt50_q, cnt50_d;
    logic [2:0]    coin_q, coin_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          short_q, short_d;
    logic [2:0]    eject_req_q, eject_req_d;
    logic          busy_q, busy_d, done_q, done_d, jam_q, jam_d;
    logic [AW-1:0] coin_val;

    function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[AW] ? {AW{1'b1}} : s[AW-1:0];
    endfunction

    assign coin_val = coin_q[2] ? AW'(5) : (coin_q[1] ? AW'(2) : AW'(1));

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        cnt10_d  = cnt10_q;
        cnt20_d  = cnt20_q;
        cnt50_d  = cnt50_q;
        coin_d   = coin_q;
        tmr_d    = tmr_q;
        short_d  = short_q;
        case (state_q)
            S_IDLE: begin
                // Refill lands in the same edge as start, so PICK sees it
                if (refill) begin
                    case (refill_sel)
                        2'd0:    cnt10_d = sat_add(cnt10_q, refill_qty);
                        2'd1:    cnt20_d = sat_add(cnt20_q, refill_qty);
                        2'd2:    cnt50_d = sat_add(cnt50_q, refill_qty);
                        default: ;
                    endcase
                end
                if (start) begin
                    remain_d = amount;
                    short_d  = 1'b0;
                    state_d  = S_PICK;
                end
            end
            S_PICK: begin
                tmr_d = '0;
                if (remain_q == '0) begin
                    state_d = S_DONE;
                end else if (remain_q >= AW'(5) && cnt50_q != '0) begin
                    coin_d  = 3'b100;
                    state_d = S_EJECT;
                end else if (remain_q >= AW'(2) && cnt20_q != '0) begin
                    coin_d  = 3'b010;
                    state_d = S_EJECT;
                end else if (cnt10_q != '0) begin
                    coin_d  = 3'b001;
                    state_d = S_EJECT;
                end else begin
                    short_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_EJECT: begin
                if (eject_ack) begin
                    case (coin_q)
                        3'b100:  cnt50_d = cnt50_q - AW'(1);
                        3'b010:  cnt20_d = cnt20_q - AW'(1);
                        default: cnt10_d = cnt10_q - AW'(1);
                    endcase
                    remain_d = remain_q - coin_val;
                    state_d  = S_RELEASE;
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_JAM;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_RELEASE: if (!eject_ack) state_d = S_PICK;
            S_DONE:    state_d = S_IDLE;
            S_JAM:     if (jam_clr) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        eject_req_d = (state_d == S_EJECT) ? coin_d : 3'b000;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        jam_d       = (state_d == S_JAM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remain_q    <= '0;
            cnt10_q     <= '0;
            cnt20_q     <= '0;
            cnt50_q     <= '0;
            coin_q      <= 3'b001;
            tmr_q       <= '0;
            short_q     <= 1'b0;
            eject_req_q <= 3'b000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            jam_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            cnt10_q     <= cnt10_d;
            cnt20_q     <= cnt20_d;
            cnt50_q     <= cnt50_d;
            coin_q      <= coin_d;
            tmr_q       <= tmr_d;
            short_q     <= short_d;
            eject_req_q <= eject_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            jam_q       <= jam_d;
        end
    end

    assign eject_req = eject_req_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign short     = short_q;
    assign jam       = jam_q;
    assign remain    = remain_q;
    assign cnt10     = cnt10_q;
    assign cnt20     = cnt20_q;
    assign cnt50     = cnt50_q;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// tb_change_dispenser : scoreboard bench for change_dispenser
// Revision: 1.0
// ============================================================================
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] amount = '0;
    logic       refill = 1'b0;
    logic [1:0] refill_sel = '0;
    logic [7:0] refill_qty = '0;
    logic       jam_clr = 1'b0;
    logic       eject_ack = 1'b0;
    logic [2:0] eject_req;
    logic       busy, done, short, jam;
    logic [7:0] remain, cnt10, cnt20, cnt50;

    int tests = 0;
    int fails = 0;

    logic [2:0] exp_q[$];
    bit         ack_en = 1'b1;
    int         ack_delay = 2;

    change_dispenser #(.AW(8), .TIMEOUT(200)) dut (
        .clk(clk), .rst(rst), .start(start), .amount(amount),
        .refill(refill), .refill_sel(refill_sel), .refill_qty(refill_qty),
        .jam_clr(jam_clr), .eject_ack(eject_ack), .eject_req(eject_req),
        .busy(busy), .done(done), .short(short), .jam(jam), .remain(remain),
        .cnt10(cnt10), .cnt20(cnt20), .cnt50(cnt50)
    );

    always #5 clk = ~clk;

    // Ejector model and coin-order scoreboard, evaluated at each falling edge
    initial begin
        logic [2:0] prev_req;
        logic [2:0] e;
        int ack_cnt;
        prev_req = 3'b000;
        ack_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!(eject_req inside {3'b000, 3'b001, 3'b010, 3'b100})) begin
                tests++; fails++;
                $display("FAIL onehot: eject_req=%b is multi-hot", eject_req);
            end
            if (eject_req != 3'b000 && prev_req == 3'b000) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL coin_order: unexpected eject_req=%b, none expected", eject_req);
                end else begin
                    e = exp_q.pop_front();
                    if (eject_req !== e) begin
                        fails++;
                        $display("FAIL coin_order: eject_req=%b expected %b", eject_req, e);
                    end
                end
            end
            prev_req = eject_req;
            if (eject_ack) begin
                if (eject_req == 3'b000) eject_ack = 1'b0;
                ack_cnt = 0;
            end else if (ack_en && eject_req != 3'b000) begin
                if (ack_cnt >= ack_delay) begin
                    eject_ack = 1'b1;
                    ack_cnt   = 0;
                end else begin
                    ack_cnt++;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    end

    task automatic do_refill(input logic [1:0] sel, input logic [7:0] qty);
        @(negedge clk);
        refill = 1'b1; refill_sel = sel; refill_qty = qty;
        @(negedge clk);
        refill = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] amt);
        start = 1'b1; amount = amt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic exp_short, input logic [7:0] exp_rem,
                             input logic [7:0] e10, input logic [7:0] e20, input logic [7:0] e50);
        int n;
        n = 0;
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL %s_done: done never asserted within budget", name);
        end
        tests++;
        if (short !== exp_short || remain !== exp_rem) begin
            fails++;
            $display("FAIL %s_result: short=%b remain=%0d expected short=%b remain=%0d",
                     name, short, remain, exp_short, exp_rem);
        end
        tests++;
        if (cnt10 !== e10 || cnt20 !== e20 || cnt50 !== e50) begin
            fails++;
            $display("FAIL %s_counts: cnt10/20/50=%0d/%0d/%0d expected %0d/%0d/%0d",
                     name, cnt10, cnt20, cnt50, e10, e20, e50);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_coins: %0d expected ejects missing", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        tests++;
        if (eject_req !== 3'b000 || busy !== 1'b0 || done !== 1'b0 || short !== 1'b0 || jam !== 1'b0 ||
            remain !== 8'd0 || cnt10 !== 8'd0 || cnt20 !== 8'd0 || cnt50 !== 8'd0) begin
            fails++;
            $display("FAIL reset: req=%b busy=%b done=%b short=%b jam=%b remain=%0d cnt=%0d/%0d/%0d expected all 0",
                     eject_req, busy, done, short, jam, remain, cnt10, cnt20, cnt50);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_greedy();
        do_refill(2'd0, 8'd10);
        do_refill(2'd1, 8'd10);
        do_refill(2'd2, 8'd10);
        tests++;
        if (cnt10 !== 8'd10 || cnt20 !== 8'd10 || cnt50 !== 8'd10) begin
            fails++;
            $display("FAIL refill: cnt10/20/50=%0d/%0d/%0d expected 10/10/10", cnt10, cnt20, cnt50);
        end
        exp_q.push_back(3'b100); exp_q.push_back(3'b010); exp_q.push_back(3'b001);
        do_start(8'd8);
        wait_done("greedy", 1'b0, 8'd0, 8'd9, 8'd9, 8'd9);
    endtask

    task automatic test_fallback();
        do_reset();
        do_refill(2'd1, 8'd1);
        do_refill(2'd0, 8'd3);
        exp_q.push_back(3'b010);
        repeat (3) exp_q.push_back(3'b001);
        do_start(8'd5);
        wait_done("fallback", 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic test_shortfall();
        do_refill(2'd0, 8'd2);
        repeat (2) exp_q.push_back(3'b001);
        do_start(8'd4);
        wait_done("shortfall", 1'b1, 8'd2, 8'd0, 8'd0, 8'd0);
        repeat (3) @(negedge clk);
        tests++;
        if (short !== 1'b1 || remain !== 8'd2) begin
            fails++;
            $display("FAIL short_hold: short=%b remain=%0d expected 1 and 2", short, remain);
        end
    endtask

    task automatic test_jam();
        int n;
        int w;
        do_refill(2'd0, 8'd1);
        ack_en = 1'b0;
        exp_q.push_back(3'b001);
        do_start(8'd1);
        w = 0;
        while (eject_req == 3'b000 && w < 10) begin
            @(negedge clk);
            w++;
        end
        n = 0;
        while (!jam && n < 300) begin
            if (eject_req != 3'b000) n++;
            @(negedge clk);
        end
        tests++;
        if (jam !== 1'b1 || n != 200) begin
            fails++;
            $display("FAIL jam_timing: jam=%b after %0d eject cycles, expected jam=1 after 200", jam, n);
        end
        tests++;
        if (eject_req !== 3'b000 || cnt10 !== 8'd1 || remain !== 8'd1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL jam_state: req=%b cnt10=%0d remain=%0d busy=%b expected 000/1/1/1",
                     eject_req, cnt10, remain, busy);
        end
        do_start(8'd3);
        tests++;
        if (jam !== 1'b1 || remain !== 8'd1) begin
            fails++;
            $display("FAIL jam_ignore_start: jam=%b remain=%0d expected 1 and 1", jam, remain);
        end
        jam_clr = 1'b1;
        @(negedge clk);
        jam_clr = 1'b0;
        tests++;
        if (jam !== 1'b0 || busy !== 1'b0 || remain !== 8'd1) begin
            fails++;
            $display("FAIL jam_clr: jam=%b busy=%b remain=%0d expected 0/0/1", jam, busy, remain);
        end
        ack_en = 1'b1;
    endtask

    task automatic test_ignored();
        do_start(8'd0);
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL zero_c1: busy=%b done=%b expected 1/0", busy, done);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b1 || done !== 1'b1 || eject_req !== 3'b000) begin
            fails++;
            $display("FAIL zero_c2: busy=%b done=%b req=%b expected 1/1/000", busy, done, eject_req);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL zero_c3: busy=%b done=%b expected 0/0", busy, done);
        end
        exp_q.push_back(3'b001);
        do_start(8'd1);
        start = 1'b1; amount = 8'd7;
        refill = 1'b1; refill_sel = 2'd0; refill_qty = 8'd5;
        @(negedge clk);
        start = 1'b0; refill = 1'b0;
        wait_done("busy_ignore", 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        do_refill(2'd2, 8'd250);
        do_refill(2'd2, 8'd10);
        do_refill(2'd3, 8'd9);
        tests++;
        if (cnt50 !== 8'd255 || cnt10 !== 8'd0 || cnt20 !== 8'd0) begin
            fails++;
            $display("FAIL saturate: cnt10/20/50=%0d/%0d/%0d expected 0/0/255", cnt10, cnt20, cnt50);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        do_reset();
        do_refill(2'd0, 8'd1);
        ack_en = 1'b0;
        exp_q.push_back(3'b001);
        do_start(8'd1);
        w = 0;
        while (eject_req == 3'b000 && w < 10) begin
            @(negedge clk);
            w++;
        end
        eject_ack = 1'b1;
        #2 rst = 1'b1;
        #1;
        tests++;
        if (eject_req !== 3'b000 || busy !== 1'b0 || done !== 1'b0 || jam !== 1'b0 ||
            remain !== 8'd0 || cnt10 !== 8'd0) begin
            fails++;
            $display("FAIL reset_mid: req=%b busy=%b done=%b jam=%b remain=%0d cnt10=%0d expected all 0",
                     eject_req, busy, done, jam, remain, cnt10);
        end
        @(negedge clk);
        rst = 1'b0;
        ack_en = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || eject_req !== 3'b000) begin
            fails++;
            $display("FAIL reset_mid_idle: busy=%b req=%b expected 0/000", busy, eject_req);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_greedy();
        test_fallback();
        test_shortfall();
        test_jam();
        test_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
